cnt_slice_ctrl: RTL and testbench



---
 rtl/cnt_ctrl_pkg.sv | 19 +
 rtl/cnt_slice4.sv | 28 ++
 rtl/cnt_slice_ctrl.sv | 108 ++++++++++
 tb/tb_cnt_slice_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the counter-slice sequencing controller.
package cnt_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_STEP  = 2'd3;

endpackage

// File: rtl/cnt_slice4.sv
// One 4-bit counter slice: synchronous load has priority over carry-in count.
module cnt_slice4
  import cnt_ctrl_pkg::*;
#(
  parameter logic [SLICE_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [SLICE_W-1:0] load_data,
  input  logic               cin,
  output logic [SLICE_W-1:0] q,
  output logic               cout
);

  assign cout = cin & (q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_data;
    end else if (cin) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_slice_ctrl.sv
// Command sequencer driving a ripple-carry cascade of cnt_slice4 counters.
// Optional macro CNT_AUTORELOAD_EN: terminal count reloads from the reload register.
module cnt_slice_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned                  NSLICE  = 2,
  parameter logic [SLICE_W*NSLICE-1:0]    RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [SLICE_W*NSLICE-1:0] cmd_data,
  input  logic                      cnt_en,
  output logic [SLICE_W*NSLICE-1:0] cnt_q,
  output logic                      tc_pulse,
  output logic                      busy,
  output logic [2:0]                state_o
);

  localparam int unsigned W = SLICE_W * NSLICE;

  state_t         state, state_nx;
  logic [W-1:0]   ldata, reload, load_val;
  logic [NSLICE:0] carry;
  logic           accept, idle_like, step_fire, run_inc, tc, slice_load;

  assign cmd_ready = (state != S_LOAD);
  assign accept    = cmd_valid & cmd_ready;
  assign idle_like = (state == S_IDLE) || (state == S_HOLD) || (state == S_DONE);
  assign step_fire = accept & idle_like & (cmd_op == OP_STEP);
  // An accepted command always suppresses the RUN increment for that cycle.
  assign run_inc   = (state == S_RUN) & cnt_en & ~accept;
  assign carry[0]  = run_inc | step_fire;
  assign tc        = carry[NSLICE];

`ifdef CNT_AUTORELOAD_EN
  assign slice_load = (state == S_LOAD) | tc;
`else
  assign slice_load = (state == S_LOAD);
`endif
  assign load_val = (state == S_LOAD) ? ldata : reload;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    cnt_slice4 #(
      .RST_VAL (RST_VAL[SLICE_W*k +: SLICE_W])
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slice_load),
      .load_data (load_val[SLICE_W*k +: SLICE_W]),
      .cin       (carry[k]),
      .q         (cnt_q[SLICE_W*k +: SLICE_W]),
      .cout      (carry[k+1])
    );
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_HOLD, S_DONE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_LOAD:  state_nx = S_LOAD;
            OP_START: state_nx = S_RUN;
            OP_STOP:  state_nx = S_HOLD;
            OP_STEP:  state_nx = S_HOLD;
            default:  state_nx = state;
          endcase
        end
      end
      S_LOAD: state_nx = S_HOLD;
      S_RUN: begin
        if (accept) begin
          if (cmd_op == OP_LOAD)      state_nx = S_LOAD;
          else if (cmd_op == OP_STOP) state_nx = S_HOLD;
        end else if (tc) begin
`ifdef CNT_AUTORELOAD_EN
          state_nx = S_RUN;
`else
          state_nx = S_DONE;
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ldata    <= RST_VAL;
      reload   <= RST_VAL;
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      tc_pulse <= tc;
      busy     <= (state_nx == S_RUN);
      if (accept && (cmd_op == OP_LOAD)) ldata <= cmd_data;
      if (state == S_LOAD)               reload <= ldata;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cnt_slice_ctrl.sv
// Directed table-driven bench for cnt_slice_ctrl (NSLICE=2), both reload builds.
module tb_cnt_slice_ctrl;

`ifdef CNT_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam logic [1:0] LD = 2'd0, ST = 2'd1, SP = 2'd2, SE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cnt_en;
  logic [7:0] cnt_q;
  logic       tc_pulse;
  logic       busy;
  logic [2:0] state_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cnt_slice_ctrl #(
    .NSLICE  (2),
    .RST_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cnt_en    (cnt_en),
    .cnt_q     (cnt_q),
    .tc_pulse  (tc_pulse),
    .busy      (busy),
    .state_o   (state_o)
  );

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [7:0] data;
    logic       en;
    logic [7:0] cnt;
    logic       tc;
    logic       bsy;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic v, logic [1:0] op, logic [7:0] d, logic en,
                              logic [7:0] c, logic t, logic b, logic [2:0] s);
    vec_t x;
    x.valid = v; x.op = op; x.data = d; x.en = en;
    x.cnt = c; x.tc = t; x.bsy = b; x.st = s;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [7:0] c, logic t, logic b, logic [2:0] s);
    chk({tag, ".cnt_q"},     cnt_q, c);
    chk({tag, ".tc_pulse"},  {7'd0, tc_pulse}, {7'd0, t});
    chk({tag, ".busy"},      {7'd0, busy}, {7'd0, b});
    chk({tag, ".state"},     {5'd0, state_o}, {5'd0, s});
    chk({tag, ".cmd_ready"}, {7'd0, cmd_ready}, {7'd0, (s != 3'd1)});
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [7:0] d, logic en);
    cmd_valid = v; cmd_op = op; cmd_data = d; cnt_en = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wrapv;

  initial begin
    wrapv = AUTO ? 8'hFF : 8'h00;
    // Terminal count from FD in RUN
    add(1, LD, 8'hFD, 0, 8'h00, 0, 0, 3'd1);
    add(0, LD, 8'h00, 0, 8'hFD, 0, 0, 3'd3);
    add(1, ST, 8'h00, 1, 8'hFD, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'hFE, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'hFF, 0, 1, 3'd2);
    if (AUTO) begin
      add(0, LD, 8'h00, 1, 8'hFD, 1, 1, 3'd2);
      add(0, LD, 8'h00, 1, 8'hFE, 0, 1, 3'd2);
      add(0, LD, 8'h00, 1, 8'hFF, 0, 1, 3'd2);
      add(0, LD, 8'h00, 1, 8'hFD, 1, 1, 3'd2);
      add(1, SP, 8'h00, 1, 8'hFD, 0, 0, 3'd3);
      add(1, LD, 8'h0F, 0, 8'hFD, 0, 0, 3'd1);
    end else begin
      add(0, LD, 8'h00, 1, 8'h00, 1, 0, 3'd4);
      add(0, LD, 8'h00, 1, 8'h00, 0, 0, 3'd4);
      add(0, LD, 8'h00, 1, 8'h00, 0, 0, 3'd4);
      add(0, LD, 8'h00, 1, 8'h00, 0, 0, 3'd4);
      add(1, SP, 8'h00, 1, 8'h00, 0, 0, 3'd3);
      add(1, LD, 8'h0F, 0, 8'h00, 0, 0, 3'd1);
    end
    // STEP across slice boundary and STEP wrap
    add(0, LD, 8'h00, 0, 8'h0F, 0, 0, 3'd3);
    add(1, SE, 8'h00, 0, 8'h10, 0, 0, 3'd3);
    add(1, LD, 8'hFF, 0, 8'h10, 0, 0, 3'd1);
    add(0, LD, 8'h00, 0, 8'hFF, 0, 0, 3'd3);
    add(1, SE, 8'h00, 0, wrapv, 1, 0, 3'd3);
    add(0, LD, 8'h00, 0, wrapv, 0, 0, 3'd3);
    // RUN with cnt_en toggling, then STOP
    add(1, LD, 8'h10, 0, wrapv, 0, 0, 3'd1);
    add(0, LD, 8'h00, 0, 8'h10, 0, 0, 3'd3);
    add(1, ST, 8'h00, 1, 8'h10, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'h11, 0, 1, 3'd2);
    add(0, LD, 8'h00, 0, 8'h11, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'h12, 0, 1, 3'd2);
    add(1, SP, 8'h00, 1, 8'h12, 0, 0, 3'd3);
    add(0, LD, 8'h00, 1, 8'h12, 0, 0, 3'd3);
    // LOAD then START held through the not-ready cycle
    add(1, LD, 8'h20, 1, 8'h12, 0, 0, 3'd1);
    add(1, ST, 8'h00, 1, 8'h20, 0, 0, 3'd3);
    add(1, ST, 8'h00, 1, 8'h20, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'h21, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'h22, 0, 1, 3'd2);
    add(1, SE, 8'h00, 1, 8'h22, 0, 1, 3'd2);
    add(0, LD, 8'h00, 1, 8'h23, 0, 1, 3'd2);
    add(1, ST, 8'h00, 1, 8'h23, 0, 1, 3'd2);
    // All-ones with cnt_en low must not fire
    add(1, LD, 8'hFF, 0, 8'h23, 0, 0, 3'd1);
    add(0, LD, 8'h00, 0, 8'hFF, 0, 0, 3'd3);
    add(1, ST, 8'h00, 0, 8'hFF, 0, 1, 3'd2);
    add(0, LD, 8'h00, 0, 8'hFF, 0, 1, 3'd2);
    if (AUTO) add(0, LD, 8'h00, 1, 8'hFF, 1, 1, 3'd2);
    else      add(0, LD, 8'h00, 1, 8'h00, 1, 0, 3'd4);

    rst_n = 1'b0;
    drive(0, LD, 8'h00, 0);
    #12;
    check_all("reset", 8'h00, 0, 0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("post_reset", 8'h00, 0, 0, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].data, vecs[i].en);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tc, vecs[i].bsy, vecs[i].st);
    end

    // Asynchronous reset mid-RUN at 0x37
    drive(1, LD, 8'h37, 0); step();
    drive(0, LD, 8'h00, 0); step();
    drive(1, ST, 8'h00, 0); step();
    drive(0, LD, 8'h00, 0); step();
    check_all("pre_areset", 8'h37, 0, 1, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("areset", 8'h00, 0, 0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, ST, 8'h00, 1); step();
    check_all("restart0", 8'h00, 0, 1, 3'd2);
    drive(0, LD, 8'h00, 1); step();
    check_all("restart1", 8'h01, 0, 1, 3'd2);
    step();
    check_all("restart2", 8'h02, 0, 1, 3'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
